// File: rtl/vco_freq_meter.sv
// -----------------------------------------------------------------------------
// vco_freq_meter
//
// Purpose:
//    Digital frequency meter for a VCO output clock. The asynchronous vco_clk
//    is brought into the clk domain through a two-flop synchronizer plus an
//    edge-detect flop. Its rising edges are counted over a gate window of
//    GATE_CYCLES system clock cycles. At the default 100000-cycle gate and a
//    100 MHz clk, the reported count equals the VCO frequency in kHz.
//    The edge counter saturates at all-ones and raises a sticky overflow flag.
//
// Parameters:
//    GATE_CYCLES  gate window length in clk cycles (>= 4)
//    COUNT_WIDTH  width of the edge counter and of the count output
//
// Ports:
//    clk          system clock
//    rst_n        asynchronous active-low reset
//    vco_clk      VCO output clock, asynchronous to clk (f_vco <= f_clk/4)
//    start        level-sampled; starts a measurement when high in IDLE
//    continuous   when high at window end, the next window starts at once
//    count        edge count of the last completed window
//    count_valid  one-cycle pulse when count/overflow are updated
//    overflow     last completed window saturated the counter
//    busy         high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module vco_freq_meter #(
   parameter int GATE_CYCLES = 100000,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   vco_clk,
   input  logic                   start,
   input  logic                   continuous,
   output logic [COUNT_WIDTH-1:0] count,
   output logic                   count_valid,
   output logic                   overflow,
   output logic                   busy
);

   // Gate counter only needs to hold GATE_CYCLES-1; GATE_CYCLES >= 4 keeps this >= 2.
   localparam int                     GW        = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 2;
   localparam logic [GW-1:0]          GATE_LOAD = GW'(GATE_CYCLES - 1);
   localparam logic [GW-1:0]          GATE_ONE  = {{(GW-1){1'b0}}, 1'b1};
   localparam logic [COUNT_WIDTH-1:0] CNT_MAX   = {COUNT_WIDTH{1'b1}};
   localparam logic [COUNT_WIDTH-1:0] CNT_ONE   = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_GATE = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Saturating increment: returns {overflow_seen, next_count}.
   // An edge arriving while already at all-ones sets the overflow bit and
   // leaves the count untouched instead of wrapping.
   function automatic logic [COUNT_WIDTH:0] sat_inc(
      input logic [COUNT_WIDTH-1:0] cnt,
      input logic                   ovf,
      input logic                   inc
   );
      logic [COUNT_WIDTH:0] res;
      res = {ovf, cnt};
      if (inc) begin
         if (cnt == CNT_MAX) begin
            res = {1'b1, cnt};
         end else begin
            res = {ovf, cnt + CNT_ONE};
         end
      end else begin
         res = {ovf, cnt};
      end
      return res;
   endfunction

   logic                   r_sync1;
   logic                   r_sync2;
   logic                   r_sync3;
   logic                   w_edge;

   state_t                 r_state;
   logic [GW-1:0]          r_gate_cnt;
   logic [COUNT_WIDTH-1:0] r_edge_cnt;
   logic                   r_ovf_int;

   logic [COUNT_WIDTH-1:0] r_count;
   logic                   r_count_valid;
   logic                   r_overflow;
   logic                   r_busy;

   logic [COUNT_WIDTH:0]   w_inc;
   logic [COUNT_WIDTH-1:0] w_edge_cnt_nxt;
   logic                   w_ovf_nxt;

   // Two-flop synchronizer for vco_clk plus a third flop for rising-edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_sync3 <= 1'b0;
      end else begin
         r_sync1 <= vco_clk;
         r_sync2 <= r_sync1;
         r_sync3 <= r_sync2;
      end
   end

   assign w_edge = r_sync2 & ~r_sync3;

   // Next edge count and sticky overflow, used both for accumulation and for
   // latching the result so that an edge in the final gate cycle is counted.
   always_comb begin
      w_inc          = sat_inc(r_edge_cnt, r_ovf_int, w_edge);
      w_edge_cnt_nxt = w_inc[COUNT_WIDTH-1:0];
      w_ovf_nxt      = w_inc[COUNT_WIDTH];
   end

   // Measurement FSM with its counters and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_IDLE;
         r_gate_cnt    <= {GW{1'b0}};
         r_edge_cnt    <= {COUNT_WIDTH{1'b0}};
         r_ovf_int     <= 1'b0;
         r_count       <= {COUNT_WIDTH{1'b0}};
         r_count_valid <= 1'b0;
         r_overflow    <= 1'b0;
         r_busy        <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_count_valid <= 1'b0;
               if (start) begin
                  r_state    <= ST_GATE;
                  r_gate_cnt <= GATE_LOAD;
                  r_edge_cnt <= {COUNT_WIDTH{1'b0}};
                  r_ovf_int  <= 1'b0;
                  r_busy     <= 1'b1;
               end else begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end
            end

            ST_GATE: begin
               r_edge_cnt <= w_edge_cnt_nxt;
               r_ovf_int  <= w_ovf_nxt;
               r_busy     <= 1'b1;
               if (r_gate_cnt == {GW{1'b0}}) begin
                  // Result is latched on the edge that ends the last gate cycle.
                  r_state       <= ST_DONE;
                  r_count       <= w_edge_cnt_nxt;
                  r_overflow    <= w_ovf_nxt;
                  r_count_valid <= 1'b1;
               end else begin
                  r_state       <= ST_GATE;
                  r_gate_cnt    <= r_gate_cnt - GATE_ONE;
                  r_count_valid <= 1'b0;
               end
            end

            ST_DONE: begin
               // Edges seen during this cycle are intentionally dropped.
               r_count_valid <= 1'b0;
               if (continuous) begin
                  r_state    <= ST_GATE;
                  r_gate_cnt <= GATE_LOAD;
                  r_edge_cnt <= {COUNT_WIDTH{1'b0}};
                  r_ovf_int  <= 1'b0;
                  r_busy     <= 1'b1;
               end else begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end
            end

            default: begin
               r_state       <= ST_IDLE;
               r_count_valid <= 1'b0;
               r_busy        <= 1'b0;
            end
         endcase
      end
   end

   assign count       = r_count;
   assign count_valid = r_count_valid;
   assign overflow    = r_overflow;
   assign busy        = r_busy;

endmodule

// File: tb/tb_vco_freq_meter.sv
// -----------------------------------------------------------------------------
// tb_vco_freq_meter
//
// Directed sequence with randomized VCO frequencies. Expected counts come from
// the ideal relation count = GATE * T_clk / T_vco with a +/-1 tolerance;
// expected timing comes from the window/period arithmetic of the meter.
// A second instance with a 4-bit counter and a 400-cycle gate covers saturation.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vco_freq_meter;

   localparam int  G      = 1000;
   localparam int  G_O    = 400;
   localparam int  CW_O   = 4;
   localparam real CLK_NS = 10.0;

   logic        clk;
   logic        rst_n;
   logic        vco_clk;
   logic        start;
   logic        continuous;
   logic [15:0] count;
   logic        count_valid;
   logic        overflow;
   logic        busy;

   logic        start_o;
   logic        continuous_o;
   logic [3:0]  count_o;
   logic        count_valid_o;
   logic        overflow_o;
   logic        busy_o;

   int  checks = 0;
   int  errors = 0;
   real vco_half_ns = 200.0;

   vco_freq_meter #(.GATE_CYCLES(G), .COUNT_WIDTH(16)) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .vco_clk     (vco_clk),
      .start       (start),
      .continuous  (continuous),
      .count       (count),
      .count_valid (count_valid),
      .overflow    (overflow),
      .busy        (busy)
   );

   vco_freq_meter #(.GATE_CYCLES(G_O), .COUNT_WIDTH(CW_O)) u_ovf (
      .clk         (clk),
      .rst_n       (rst_n),
      .vco_clk     (vco_clk),
      .start       (start_o),
      .continuous  (continuous_o),
      .count       (count_o),
      .count_valid (count_valid_o),
      .overflow    (overflow_o),
      .busy        (busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // VCO model: half period re-read every half cycle so frequency steps take effect.
   initial begin
      vco_clk = 1'b0;
      #3.3;
      forever begin
         #(vco_half_ns) vco_clk = ~vco_clk;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
      checks++;
      assert (((obs >= lo) && (obs <= hi)) === 1'b1) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
      end
   endtask

   // Ideal count bounds for a gate of g cycles at the given VCO half period.
   function automatic void exp_range(input real half_ns, input int g, output int lo, output int hi);
      real x;
      x  = (g * CLK_NS) / (2.0 * half_ns);
      lo = $rtoi($ceil(x)) - 1;
      hi = $rtoi($floor(x)) + 1;
   endfunction

   // Ticks until count_valid of the chosen instance is seen, at most bound ticks.
   task automatic wait_valid(input bit sel, input int bound, output int n);
      n = 0;
      while (n < bound) begin
         tick();
         n++;
         if ((sel ? count_valid_o : count_valid) === 1'b1) break;
      end
   endtask

   task automatic set_freq(input real half_ns);
      vco_half_ns = half_ns;
      repeat (50) tick();
   endtask

   task automatic quiet_cycles(input string tag, input int cycles);
      int extra;
      extra = 0;
      repeat (cycles) begin
         tick();
         if (count_valid === 1'b1) extra++;
      end
      chk(tag, extra, 32'd0);
   endtask

   task automatic single_shot(input string tag);
      int n, lo, hi;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk({tag, "_busy_rise"}, busy, 32'd1);
      wait_valid(1'b0, G + 20, n);
      chk({tag, "_latency"}, n, G);
      exp_range(vco_half_ns, G, lo, hi);
      chk_rng({tag, "_count"}, count, lo, hi);
      chk({tag, "_ovf"}, overflow, 32'd0);
      tick();
      chk({tag, "_valid_drop"}, count_valid, 32'd0);
      chk({tag, "_busy_fall"}, busy, 32'd0);
      quiet_cycles({tag, "_no_extra_valid"}, 50);
   endtask

   initial begin
      int n, lo, hi;
      rst_n        = 1'b0;
      start        = 1'b0;
      continuous   = 1'b0;
      start_o      = 1'b0;
      continuous_o = 1'b0;

      // Reset values
      repeat (5) tick();
      rst_n = 1'b1;
      chk("rst_count", count, 32'd0);
      chk("rst_valid", count_valid, 32'd0);
      chk("rst_ovf", overflow, 32'd0);
      chk("rst_busy", busy, 32'd0);
      repeat (10) tick();
      chk("idle_stays", busy, 32'd0);

      // Single shot at 2.5 MHz, then at random frequencies
      set_freq(200.0);
      single_shot("shot_2m5");
      for (int i = 0; i < 4; i++) begin
         set_freq($urandom_range(21000, 250000) / 1000.0);
         single_shot("shot_rand");
      end

      // Continuous mode with a frequency step to 12.5 MHz mid-window
      set_freq($urandom_range(21000, 250000) / 1000.0);
      continuous = 1'b1;
      start      = 1'b1;
      tick();
      start = 1'b0;
      wait_valid(1'b0, G + 20, n);
      chk("cont_first", n, G);
      exp_range(vco_half_ns, G, lo, hi);
      chk_rng("cont_first_count", count, lo, hi);
      repeat (500) tick();
      vco_half_ns = 40.0;
      wait_valid(1'b0, G + 20, n);
      chk("cont_step_spacing", n, G + 1 - 500);
      wait_valid(1'b0, G + 20, n);
      chk("cont_spacing", n, G + 1);
      chk_rng("cont_12m5_count", count, 124, 126);
      repeat (300) tick();
      continuous = 1'b0;
      wait_valid(1'b0, G + 20, n);
      chk("cont_last_spacing", n, G + 1 - 300);
      chk_rng("cont_last_count", count, 124, 126);
      tick();
      chk("cont_idle_busy", busy, 32'd0);
      quiet_cycles("cont_no_more_valid", G + 50);

      // Held start re-arms through one IDLE cycle
      set_freq($urandom_range(21000, 250000) / 1000.0);
      start = 1'b1;
      tick();
      wait_valid(1'b0, G + 20, n);
      chk("held_first", n, G);
      wait_valid(1'b0, G + 20, n);
      chk("held_spacing", n, G + 2);
      exp_range(vco_half_ns, G, lo, hi);
      chk_rng("held_count", count, lo, hi);
      start = 1'b0;
      repeat (2) tick();
      chk("held_release_busy", busy, 32'd0);

      // Start while busy is ignored
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (300) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_valid(1'b0, G + 20, n);
      chk("busy_start_latency", n, G - 301);
      tick();
      chk("busy_start_idle", busy, 32'd0);
      quiet_cycles("busy_start_single_valid", G + 50);

      // Asynchronous reset mid-window
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (500) tick();
      #3;
      rst_n = 1'b0;
      #1;
      chk("midrst_count", count, 32'd0);
      chk("midrst_busy", busy, 32'd0);
      chk("midrst_valid", count_valid, 32'd0);
      repeat (3) tick();
      rst_n = 1'b1;
      quiet_cycles("midrst_no_valid", G + 50);
      set_freq($urandom_range(21000, 250000) / 1000.0);
      single_shot("after_rst");

      // Saturation on the 4-bit / 400-cycle instance
      set_freq(40.0);
      start_o = 1'b1;
      tick();
      start_o = 1'b0;
      wait_valid(1'b1, G_O + 20, n);
      chk("ovf_latency", n, G_O);
      chk("ovf_sat_count", count_o, 32'd15);
      chk("ovf_flag", overflow_o, 32'd1);

      set_freq($urandom_range(21000, 100000) / 1000.0);
      start_o = 1'b1;
      tick();
      start_o = 1'b0;
      wait_valid(1'b1, G_O + 20, n);
      chk("ovf_rand_count", count_o, 32'd15);
      chk("ovf_rand_flag", overflow_o, 32'd1);

      set_freq(200.0);
      start_o = 1'b1;
      tick();
      start_o = 1'b0;
      wait_valid(1'b1, G_O + 20, n);
      chk_rng("novf_count", count_o, 9, 11);
      chk("novf_flag", overflow_o, 32'd0);

      set_freq($urandom_range(140000, 250000) / 1000.0);
      start_o = 1'b1;
      tick();
      start_o = 1'b0;
      wait_valid(1'b1, G_O + 20, n);
      exp_range(vco_half_ns, G_O, lo, hi);
      chk_rng("novf_rand_count", count_o, lo, hi);
      chk("novf_rand_flag", overflow_o, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
